// File: rtl/add_slice_sequencer_if.sv
// Handshake and operand/result bundle for the slice-serial adder.
// The master side requests adds; the slave side is the sequencer.
interface add_slice_sequencer_if #(
   parameter int NSLICE = 4
);
   localparam int W = 3 * NSLICE;

   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         c_out;

   modport master (output start, a, b, c_in,
                   input  ready, busy, done, sum, c_out);
   modport slave  (input  start, a, b, c_in,
                   output ready, busy, done, sum, c_out);
endinterface

// File: rtl/add_slice_sequencer.sv
// Wide unsigned add built from one 3-bit adder slice reused once per clock,
// LSB slice first, with the carry chained through a register.
module add_slice_sequencer #(
   parameter int NSLICE = 4
) (
   input  logic                clk,
   input  logic                rst,
   add_slice_sequencer_if.slave bus
);
   localparam int W  = 3 * NSLICE;
   localparam int CW = $clog2(NSLICE) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           carry_q, carry_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic           cout_q, cout_d;
   logic [2:0]     sl_a, sl_b;
   logic [3:0]     sl_res;
   logic           last_slice;

   // The shared slice: operand bits selected by the counter.
   always_comb begin
      sl_a = '0;
      sl_b = '0;
      for (int k = 0; k < NSLICE; k++) begin
         if (cnt_q == CW'(k)) begin
            sl_a = a_q[3*k +: 3];
            sl_b = b_q[3*k +: 3];
         end
      end
      sl_res     = {1'b0, sl_a} + {1'b0, sl_b} + {3'b000, carry_q};
      last_slice = (cnt_q == CW'(NSLICE - 1));
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
               carry_d = bus.c_in;
               cnt_d   = '0;
               sum_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int k = 0; k < NSLICE; k++) begin
               if (cnt_q == CW'(k)) sum_d[3*k +: 3] = sl_res[2:0];
            end
            carry_d = sl_res[3];
            if (last_slice) begin
               cout_d  = sl_res[3];
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign bus.ready = (state_q == IDLE);
   assign bus.busy  = (state_q == RUN);
   assign bus.done  = (state_q == DONE);
   assign bus.sum   = sum_q;
   assign bus.c_out = cout_q;
endmodule

// File: tb/tb_add_slice_sequencer.sv
// Randomized and directed checks of the slice-serial adder at NSLICE=4 and
// NSLICE=1 against a plain-arithmetic reference model.
module tb_add_slice_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   add_slice_sequencer_if #(.NSLICE(4)) bus4 ();
   add_slice_sequencer_if #(.NSLICE(1)) bus1 ();

   add_slice_sequencer #(.NSLICE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
   add_slice_sequencer #(.NSLICE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // w=1 selects the 4-slice instance, w=0 the 1-slice instance.
   task automatic drive(input bit w, input logic [11:0] a, input logic [11:0] b,
                        input logic ci, input logic st);
      if (w) begin
         bus4.a = a; bus4.b = b; bus4.c_in = ci; bus4.start = st;
      end else begin
         bus1.a = a[2:0]; bus1.b = b[2:0]; bus1.c_in = ci; bus1.start = st;
      end
   endtask

   function automatic logic [2:0] status(input bit w);
      return w ? {bus4.ready, bus4.busy, bus4.done} : {bus1.ready, bus1.busy, bus1.done};
   endfunction

   function automatic logic [12:0] result(input bit w);
      return w ? {bus4.c_out, bus4.sum} : {9'd0, bus1.c_out, bus1.sum};
   endfunction

   // One add; with disturb, operands are scrambled and start held high
   // through RUN and DONE to show both are ignored.
   task automatic do_add(input bit w, input logic [11:0] a_in, input logic [11:0] b_in,
                         input logic ci, input bit disturb);
      int          ns    = w ? 4 : 1;
      logic [11:0] mask  = w ? 12'hFFF : 12'h007;
      logic [11:0] a     = a_in & mask;
      logic [11:0] b     = b_in & mask;
      logic [12:0] exp   = {1'b0, a} + {1'b0, b} + {12'd0, ci};
      int          nbusy = 0;
      bit          seen  = 0;
      @(negedge clk);
      chk("ready_before_start", 32'(status(w)), 32'(3'b100));
      drive(w, a, b, ci, 1'b1);
      for (int c = 0; c < ns + 4 && !seen; c++) begin
         @(negedge clk);
         if (status(w)[0]) seen = 1;
         else if (status(w)[1]) nbusy++;
         if (disturb) drive(w, 12'($urandom), 12'($urandom), 1'($urandom), 1'b1);
         else         drive(w, a, b, ci, 1'b0);
      end
      chk("done_seen", 32'(seen), 32'd1);
      chk("busy_cycles", 32'(nbusy), 32'(ns));
      chk("sum_cout", 32'(result(w)), 32'(exp));
      @(negedge clk);
      chk("after_done_idle", 32'(status(w)), 32'(3'b100));
      drive(w, a, b, ci, 1'b0);
      @(negedge clk);
      chk("no_second_done", 32'(status(w)), 32'(3'b100));
      chk("result_held", 32'(result(w)), 32'(exp));
   endtask

   initial begin
      drive(1'b1, 12'd0, 12'd0, 1'b0, 1'b0);
      drive(1'b0, 12'd0, 12'd0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("rst_idle_status4", 32'(status(1'b1)), 32'(3'b100));
         chk("rst_idle_result4", 32'(result(1'b1)), 32'd0);
         chk("rst_idle_status1", 32'(status(1'b0)), 32'(3'b100));
         chk("rst_idle_result1", 32'(result(1'b0)), 32'd0);
      end

      do_add(1'b1, 12'hFFF, 12'h001, 1'b0, 1'b0);
      chk("ripple_all", 32'(result(1'b1)), 32'h1000);
      do_add(1'b1, 12'h5A5, 12'h3C3, 1'b1, 1'b0);
      chk("pattern_5a5", 32'(result(1'b1)), 32'h0969);
      do_add(1'b1, 12'h123, 12'h456, 1'b0, 1'b1);
      do_add(1'b1, 12'hFFF, 12'hFFF, 1'b1, 1'b1);

      for (int i = 0; i < 40; i++)
         do_add(1'b1, 12'($urandom), 12'($urandom), 1'($urandom), 1'($urandom));

      // Abort mid-add: leave a carried-out result in place first.
      do_add(1'b1, 12'hFFF, 12'h001, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 12'h555, 12'h222, 1'b0, 1'b1);
      @(negedge clk);
      drive(1'b1, 12'h555, 12'h222, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      chk("midop_busy", 32'(status(1'b1)), 32'(3'b010));
      #2 rst = 1'b1;
      #1;
      chk("midop_rst_status", 32'(status(1'b1)), 32'(3'b100));
      chk("midop_rst_result", 32'(result(1'b1)), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("midop_no_done", 32'(status(1'b1)), 32'(3'b100));
      end
      do_add(1'b1, 12'h800, 12'h800, 1'b0, 1'b0);
      chk("after_abort_800", 32'(result(1'b1)), 32'h1000);

      for (int a = 0; a < 8; a++)
         for (int b = 0; b < 8; b++)
            for (int c = 0; c < 2; c++)
               do_add(1'b0, 12'(a), 12'(b), 1'(c), 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
